imem_loader: RTL and testbench

Boot-time instruction encoder and loader for the single-cycle MIPS core. It accepts symbolic instructions over a valid/ready stream and encodes each one into a 32-bit MIPS word. It writes the words sequentially into instruction memory from word address 0 and holds the CPU in reset until loading completes. It is the producing end of the opcode/funct fields that the core's control decoder consumes: it emits exactly the opcode and funct encodings that decoder recognises.

---
 rtl/imem_loader.sv | 165 ++++++++++++++++
 tb/tb_imem_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// +----------------------------------------------------------------------------+
// | imem_loader: encodes symbolic MIPS instructions and streams them into     |
// | instruction memory from address 0, holding the CPU in reset until done.  |
// | Rev 1.0                                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module imem_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_kind,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [15:0]   in_imm,
  input  logic [25:0]   in_target,
  input  logic          in_last,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_reset,
  output logic          done,
  output logic          full,
  output logic          err,
  output logic [AW:0]   n_words
);

  localparam logic [3:0] C_K_ADD  = 4'd0;
  localparam logic [3:0] C_K_SUB  = 4'd1;
  localparam logic [3:0] C_K_AND  = 4'd2;
  localparam logic [3:0] C_K_OR   = 4'd3;
  localparam logic [3:0] C_K_SLT  = 4'd4;
  localparam logic [3:0] C_K_LW   = 4'd5;
  localparam logic [3:0] C_K_SW   = 4'd6;
  localparam logic [3:0] C_K_BEQ  = 4'd7;
  localparam logic [3:0] C_K_ADDI = 4'd8;
  localparam logic [3:0] C_K_J    = 4'd9;
  localparam logic [3:0] C_K_BNE  = 4'd10;

  localparam logic [5:0] C_OP_RTYPE = 6'h00;
  localparam logic [5:0] C_OP_LW    = 6'h23;
  localparam logic [5:0] C_OP_SW    = 6'h2B;
  localparam logic [5:0] C_OP_BEQ   = 6'h04;
  localparam logic [5:0] C_OP_BNE   = 6'h05;
  localparam logic [5:0] C_OP_ADDI  = 6'h08;
  localparam logic [5:0] C_OP_J     = 6'h02;

  localparam logic [5:0] C_FN_ADD = 6'h20;
  localparam logic [5:0] C_FN_SUB = 6'h22;
  localparam logic [5:0] C_FN_AND = 6'h24;
  localparam logic [5:0] C_FN_OR  = 6'h25;
  localparam logic [5:0] C_FN_SLT = 6'h2A;

  localparam logic [AW:0] C_LAST_ADDR = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] C_ONE       = (AW+1)'(1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_ready;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic          r_done;
  logic          r_full;
  logic          r_err;
  logic [AW:0]   r_n_words;

  logic [31:0]   w_enc;
  logic          w_legal;
  logic          w_xfer;
  logic          w_fill;

  always_comb begin
    w_enc   = 32'h0;
    w_legal = 1'b1;
    case (in_kind)
      C_K_ADD:  w_enc = {C_OP_RTYPE, in_rs, in_rt, in_rd, 5'h00, C_FN_ADD};
      C_K_SUB:  w_enc = {C_OP_RTYPE, in_rs, in_rt, in_rd, 5'h00, C_FN_SUB};
      C_K_AND:  w_enc = {C_OP_RTYPE, in_rs, in_rt, in_rd, 5'h00, C_FN_AND};
      C_K_OR:   w_enc = {C_OP_RTYPE, in_rs, in_rt, in_rd, 5'h00, C_FN_OR};
      C_K_SLT:  w_enc = {C_OP_RTYPE, in_rs, in_rt, in_rd, 5'h00, C_FN_SLT};
      C_K_LW:   w_enc = {C_OP_LW,   in_rs, in_rt, in_imm};
      C_K_SW:   w_enc = {C_OP_SW,   in_rs, in_rt, in_imm};
      C_K_BEQ:  w_enc = {C_OP_BEQ,  in_rs, in_rt, in_imm};
      C_K_ADDI: w_enc = {C_OP_ADDI, in_rs, in_rt, in_imm};
      C_K_J:    w_enc = {C_OP_J, in_target};
      C_K_BNE:  w_enc = {C_OP_BNE,  in_rs, in_rt, in_imm};
      default:  w_legal = 1'b0;
    endcase
  end

  assign w_xfer = in_valid & r_ready;
  assign w_fill = w_legal & (r_n_words == C_LAST_ADDR);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= ST_LOAD;
      r_ready   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= 32'h0;
      r_done    <= 1'b0;
      r_full    <= 1'b0;
      r_err     <= 1'b0;
      r_n_words <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          r_ready <= 1'b1;
          if (w_xfer) begin
            if (w_legal) begin
              r_we      <= 1'b1;
              r_addr    <= r_n_words[AW-1:0];
              r_wdata   <= w_enc;
              r_n_words <= r_n_words + C_ONE;
            end else begin
              r_err <= 1'b1;
            end
            // Either end condition stops acceptance immediately; done follows one cycle later.
            if (in_last || w_fill) begin
              r_state <= ST_FLUSH;
              r_ready <= 1'b0;
              if (w_fill && !in_last) begin
                r_full <= 1'b1;
              end
            end
          end
        end
        ST_FLUSH: begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= ST_DONE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Gate with resetn so the core sees no readiness while reset is asserted.
  assign in_ready   = r_ready & resetn;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign done       = r_done;
  assign cpu_reset  = ~r_done;
  assign full       = r_full;
  assign err        = r_err;
  assign n_words    = r_n_words;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// +----------------------------------------------------------------------------+
// | tb_imem_loader: scoreboard bench for imem_loader with a 4-word memory.   |
// | Rev 1.0                                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_imem_loader;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk;
  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_kind;
  logic [4:0]    in_rs;
  logic [4:0]    in_rt;
  logic [4:0]    in_rd;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          in_last;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          done;
  logic          full;
  logic          err;
  logic [AW:0]   n_words;

  int checks = 0;
  int errors = 0;
  logic [AW+31:0] r_exp_q[$];
  logic [AW-1:0]  r_exp_addr;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) u_dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kind    (in_kind),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_imm     (in_imm),
    .in_target  (in_target),
    .in_last    (in_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .full       (full),
    .err        (err),
    .n_words    (n_words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the oldest expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      checks++;
      if (r_exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected actual addr=%0d data=%h expected none", imem_addr, imem_wdata);
      end else begin
        logic [AW+31:0] e;
        e = r_exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          errors++;
          $display("FAIL strobe actual addr=%0d data=%h expected addr=%0d data=%h",
                   imem_addr, imem_wdata, e[AW+31:32], e[31:0]);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    resetn   = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr_data", 32'(imem_addr) | imem_wdata, 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_flags", {29'd0, done, full, err}, 32'd0);
    chk("rst_n_words", 32'(n_words), 32'd0);
    chk("rst_queue_empty", 32'(r_exp_q.size()), 32'd0);
    r_exp_q.delete();
    r_exp_addr = '0;
    resetn = 1'b1;
  endtask

  // Presents one instruction and waits (bounded) for the handshake edge.
  task automatic send(input logic [3:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                      input logic last, input logic legal, input logic [31:0] word);
    int n;
    @(negedge clk);
    in_valid  = 1'b1;
    in_kind   = kind;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_imm    = imm;
    in_target = tgt;
    in_last   = last;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout actual in_ready=%b expected 1", in_ready);
      in_valid = 1'b0;
    end else begin
      if (legal) begin
        r_exp_q.push_back({r_exp_addr, word});
        r_exp_addr = r_exp_addr + 1'b1;
      end
      @(posedge clk);
    end
  endtask

  task automatic idle(input int cycles);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_imm = '0; in_target = '0; in_last = 1'b0; r_exp_addr = '0;

    // Encode and write: R-type ignores imm/target garbage
    do_reset();
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'hFFFF, 26'h3FFFFFF, 1'b0, 1'b1, 32'h00221820);
    idle(2);
    chk("add_n_words", 32'(n_words), 32'd1);
    chk("add_not_done", {30'd0, done, cpu_reset}, 32'd1);
    chk("add_ready", 32'(in_ready), 32'd1);

    // Back-to-back LW, BEQ, J(last)
    do_reset();
    send(4'd5, 5'd0, 5'd2, 5'd31, 16'h0050, 26'h0, 1'b0, 1'b1, 32'h8C020050);
    send(4'd7, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 1'b0, 1'b1, 32'h1022FFFF);
    send(4'd9, 5'd7, 5'd7, 5'd7, 16'h1234, 26'h11, 1'b1, 1'b1, 32'h08000011);
    @(negedge clk);
    chk("j_ready_low", 32'(in_ready), 32'd0);
    chk("j_strobe", 32'(imem_we), 32'd1);
    chk("j_done_not_yet", 32'(done), 32'd0);
    @(negedge clk);
    chk("j_done", {30'd0, done, cpu_reset}, 32'd2);
    chk("j_n_words", 32'(n_words), 32'd3);
    idle(2);

    // Illegal kind then ADDI(last)
    do_reset();
    send(4'd12, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_no_write", 32'(n_words), 32'd0);
    send(4'd8, 5'd0, 5'd4, 5'd9, 16'h0007, 26'h0, 1'b1, 1'b1, 32'h20040007);
    idle(2);
    chk("addi_done", 32'(done), 32'd1);
    chk("addi_n_words", 32'(n_words), 32'd1);
    chk("addi_err_sticky", 32'(err), 32'd1);

    // Fill without in_last: SUB, AND, OR, SLT
    do_reset();
    send(4'd1, 5'd5, 5'd6, 5'd7, 16'h0, 26'h0, 1'b0, 1'b1, 32'h00A63822);
    send(4'd2, 5'd1, 5'd1, 5'd1, 16'hAAAA, 26'h0, 1'b0, 1'b1, 32'h00210824);
    send(4'd3, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0, 1'b0, 1'b1, 32'h00432025);
    send(4'd4, 5'd31, 5'd0, 5'd1, 16'h0, 26'h0, 1'b0, 1'b1, 32'h03E0082A);
    @(negedge clk);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("fill_done", {30'd0, done, cpu_reset}, 32'd2);
    repeat (3) @(negedge clk);
    chk("fill_no_fifth", 32'(in_ready), 32'd0);
    chk("fill_n_words", 32'(n_words), 32'd4);
    idle(1);

    // Reset mid-load: SW, BNE, then reset coinciding with a third request
    do_reset();
    send(4'd6, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 1'b0, 1'b1, 32'hAFA80004);
    send(4'd10, 5'd3, 5'd0, 5'd0, 16'hFFFE, 26'h0, 1'b0, 1'b1, 32'h1460FFFE);
    @(negedge clk);
    resetn = 1'b0;
    in_kind = 4'd0; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3;
    @(negedge clk);
    chk("midrst_we", 32'(imem_we), 32'd0);
    chk("midrst_n_words", 32'(n_words), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd0);
    chk("midrst_cpu_reset", {29'd0, cpu_reset, done, full | err}, 32'd4);
    chk("midrst_queue", 32'(r_exp_q.size()), 32'd0);
    r_exp_addr = '0;
    resetn = 1'b1;
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 1'b1, 32'h00221820);
    idle(2);
    chk("midrst_restart_n", 32'(n_words), 32'd1);

    // Back-pressure: bubbles between transfers
    do_reset();
    idle(3);
    send(4'd3, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0, 1'b0, 1'b1, 32'h00432025);
    idle(2);
    send(4'd10, 5'd3, 5'd0, 5'd0, 16'hFFFE, 26'h0, 1'b0, 1'b1, 32'h1460FFFE);
    idle(1);
    send(4'd5, 5'd0, 5'd2, 5'd0, 16'h0050, 26'h0, 1'b1, 1'b1, 32'h8C020050);
    idle(3);
    chk("bp_n_words", 32'(n_words), 32'd3);
    chk("bp_done", 32'(done), 32'd1);
    chk("bp_queue_drained", 32'(r_exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
